// File: rtl/pwm32_pkg.sv
// -----------------------------------------------------------------------------
// pwm32_pkg
// Shared definitions for the 32-bit PWM timing core:
//   - state_t       : FSM state encoding (IDLE, RUN)
//   - CNT_W_DEFAULT : default width of prescaler, timer and compare values
//   - RST_*         : reset values of the registered outputs
// -----------------------------------------------------------------------------
package pwm32_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam state_t RST_STATE      = IDLE;
    localparam logic   RST_PWM        = 1'b0;
    localparam logic   RST_PERIOD_END = 1'b0;
    localparam logic   RST_IRQ        = 1'b0;

endpackage

// File: rtl/pwm32_prescaler.sv
// -----------------------------------------------------------------------------
// pwm32_prescaler
// Prescaler counter for the PWM timing core. Produces a one-cycle tick every
// pre+1 clock cycles while run is high.
//
// Ports:
//   PCLK     in   clock
//   PRESETn  in   asynchronous active-low reset
//   run      in   count enable; when low the counter is held at zero
//   reload   in   clears the counter (new shadow values being loaded)
//   pre      in   shadowed divisor minus one
//   tick     out  combinational tick, high when the count reaches pre
// -----------------------------------------------------------------------------
module pwm32_prescaler
    import pwm32_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             run,
    input  logic             reload,
    input  logic [CNT_W-1:0] pre,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count;

    // pre = 0 ticks every cycle; pre = all-ones ticks once per 2^CNT_W cycles.
    assign tick = run & ~reload & (count == pre);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (!run || reload || tick) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pwm32_core.sv
// -----------------------------------------------------------------------------
// pwm32_core
// Timing core of the 32-bit PWM peripheral. A prescaled up-counter runs from
// 0 to cmp1_sh (period) and the pin is high while the count is below cmp2_sh
// (duty). PRE/TMRCMP1/TMRCMP2 are captured into shadow registers on enable
// and at each period wrap, so register writes never glitch the waveform.
//
// Optional feature: define PWM32_IRQ_EN to add a sticky period interrupt
// (irq_clr input, irq output).
//
// Ports:
//   PCLK        in   clock
//   PRESETn     in   asynchronous active-low reset
//   PRE         in   prescale divisor minus one
//   TMRCMP1     in   period minus one, in ticks
//   TMRCMP2     in   high time, in ticks
//   TMREN       in   counter enable
//   irq_clr     in   clears irq           (PWM32_IRQ_EN only)
//   irq         out  sticky period flag   (PWM32_IRQ_EN only)
//   pwm         out  registered PWM waveform
//   period_end  out  one-cycle pulse at each period wrap
//   busy        out  high while the FSM is in RUN
// -----------------------------------------------------------------------------
module pwm32_core
    import pwm32_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [CNT_W-1:0] PRE,
    input  logic [CNT_W-1:0] TMRCMP1,
    input  logic [CNT_W-1:0] TMRCMP2,
    input  logic             TMREN,
`ifdef PWM32_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic             pwm,
    output logic             period_end,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic             run;
    logic             start;
    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] pre_sh;
    logic [CNT_W-1:0] cmp1_sh;
    logic [CNT_W-1:0] cmp2_sh;

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= RST_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (TMREN)  state_next = RUN;
            RUN:     if (!TMREN) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs. run is RUN qualified by TMREN so a disable wins over any
    // tick, wrap or pwm update on the same edge.
    always_comb begin
        busy  = (state == RUN);
        run   = (state == RUN) & TMREN;
        start = (state == IDLE) & TMREN;
        wrap  = run & tick & (timer == cmp1_sh);
    end

    pwm32_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .run     (run),
        .reload  (start),
        .pre     (pre_sh),
        .tick    (tick)
    );

    // Shadow registers: loaded on enable and at every period wrap only.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pre_sh  <= '0;
            cmp1_sh <= '0;
            cmp2_sh <= '0;
        end else if (start || wrap) begin
            pre_sh  <= PRE;
            cmp1_sh <= TMRCMP1;
            cmp2_sh <= TMRCMP2;
        end
    end

    // Timer advances on prescaler ticks and is held at zero outside RUN.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            timer <= '0;
        end else if (!run || wrap) begin
            timer <= '0;
        end else if (tick) begin
            timer <= timer + ONE;
        end
    end

    // Output flops. pwm compares the pre-edge timer, so the pin lags the
    // counter by one cycle. cmp2_sh = 0 gives 0 %, cmp2_sh > cmp1_sh gives 100 %.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pwm        <= RST_PWM;
            period_end <= RST_PERIOD_END;
        end else begin
            pwm        <= run & (timer < cmp2_sh);
            period_end <= wrap;
        end
    end

`ifdef PWM32_IRQ_EN
    // Sticky flag; a wrap on the same edge as irq_clr keeps it set.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq <= RST_IRQ;
        end else if (wrap) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pwm32_core.sv
// -----------------------------------------------------------------------------
// tb_pwm32_core
// Directed self-checking bench for pwm32_core. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_pwm32_core;

    localparam int W = 32;

    logic         PCLK = 1'b0;
    logic         PRESETn = 1'b0;
    logic [W-1:0] PRE = '0;
    logic [W-1:0] TMRCMP1 = '0;
    logic [W-1:0] TMRCMP2 = '0;
    logic         TMREN = 1'b0;
    logic         pwm;
    logic         period_end;
    logic         busy;
`ifdef PWM32_IRQ_EN
    logic         irq_clr = 1'b0;
    logic         irq;
`endif

    int total = 0;
    int bad   = 0;

    pwm32_core #(.CNT_W(W)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .PRE        (PRE),
        .TMRCMP1    (TMRCMP1),
        .TMRCMP2    (TMRCMP2),
        .TMREN      (TMREN),
`ifdef PWM32_IRQ_EN
        .irq_clr    (irq_clr),
        .irq        (irq),
`endif
        .pwm        (pwm),
        .period_end (period_end),
        .busy       (busy)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Leave RUN, load new live values, enable; returns just after the
    // enabling edge (E0), where the FSM is in RUN and pwm is still 0.
    task automatic start(input logic [W-1:0] p, input logic [W-1:0] c1, input logic [W-1:0] c2);
        TMREN = 1'b0;
        step();
        PRE = p; TMRCMP1 = c1; TMRCMP2 = c2;
        TMREN = 1'b1;
        step();
        chk("start_busy", busy, 1);
        chk("start_pwm", pwm, 0);
    endtask

    // Step n cycles; bit n-1 of the vectors is expected after the first edge.
    task automatic run_check(input string tag, input int n, input logic [31:0] ep, input logic [31:0] ee);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_pwm[%0d]", tag, i), pwm, ep[n-1-i]);
            chk($sformatf("%s_pe[%0d]", tag, i), period_end, ee[n-1-i]);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_pwm", pwm, 0);
        chk("rst_pe", period_end, 0);
        chk("rst_busy", busy, 0);
`ifdef PWM32_IRQ_EN
        chk("rst_irq", irq, 0);
`endif
        step();
        PRESETn = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // PRE=0, period 4, high 2
        start(0, 3, 2);
`ifdef PWM32_IRQ_EN
        chk("irq_before", irq, 0);
        run_check("basic", 4, 32'b1100, 32'b0001);
        chk("irq_first_wrap", irq, 1);
        irq_clr = 1'b1;
        run_check("irqclr", 4, 32'b1100, 32'b0001);
        chk("irq_set_wins", irq, 1);
        step();
        chk("irq_cleared", irq, 0);
        irq_clr = 1'b0;
        run_check("basic2", 3, 32'b100, 32'b001);
`else
        run_check("basic", 8, 32'b11001100, 32'b00010001);
`endif

        // PRE=2: period 6 cycles, 3 high / 3 low
        start(2, 1, 1);
        run_check("presc", 12, 32'b111000111000, 32'b000001000001);

        // Duty extremes
        start(0, 3, 0);
        run_check("duty0", 8, 32'b00000000, 32'b00010001);
        start(0, 3, 5);
        run_check("duty100", 8, 32'b11111111, 32'b00010001);

        // Mid-period write of TMRCMP2 takes effect only after the wrap
        start(0, 3, 2);
        run_check("mid_a", 1, 32'b1, 32'b0);
        TMRCMP2 = 1;
        run_check("mid_b", 8, 32'b10010001, 32'b00100010);

        // Disable with timer=2, then re-enable with fresh values
        start(0, 3, 2);
        run_check("dis_a", 2, 32'b11, 32'b00);
        TMREN = 1'b0;
        step();
        chk("dis_pwm", pwm, 0);
        chk("dis_busy", busy, 0);
        chk("dis_pe", period_end, 0);
        start(0, 1, 1);
        run_check("reen", 4, 32'b1010, 32'b0101);

        // Asynchronous reset mid-run
        start(0, 3, 2);
        run_check("ares_a", 2, 32'b11, 32'b00);
        PRESETn = 1'b0;
        #1;
        chk("ares_pwm", pwm, 0);
        chk("ares_busy", busy, 0);
        chk("ares_pe", period_end, 0);
`ifdef PWM32_IRQ_EN
        chk("ares_irq", irq, 0);
`endif
        step();
        step();
        chk("ares_hold_busy", busy, 0);
        PRESETn = 1'b1;
        step();
        chk("ares_rerun_busy", busy, 1);
        chk("ares_rerun_pwm", pwm, 0);
        run_check("ares_b", 4, 32'b1100, 32'b0001);

        TMREN = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
